// File: rtl/fifo_prog_sync_if.sv
// fifo_prog_sync_if: handshake, status and control bundle for fifo_prog_sync.
//   master  - producer/consumer side: drives wr_en/wr_data, rd_en, thresholds
//             and clr_err; observes read data and all status flags.
//   slave   - FIFO side: the mirror image of master.
interface fifo_prog_sync_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256
);
   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [PTR_WIDTH:0]    af_thresh;
   logic [PTR_WIDTH:0]    ae_thresh;
   logic [PTR_WIDTH:0]    count;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, af_thresh, ae_thresh, clr_err,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );
endinterface

// File: rtl/fifo_prog_sync.sv
// fifo_prog_sync: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, sticky
// overflow/underflow flags and optional first-word-fall-through reads.
//   clk  - system clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - fifo_prog_sync_if.slave: write/read handshake, read data,
//          status flags, thresholds, count and error flags/clear
module fifo_prog_sync #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned PTR_WIDTH  = $clog2(DEPTH),
   parameter bit          FWFT       = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   fifo_prog_sync_if.slave      bus
);

   localparam logic [PTR_WIDTH:0]   DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   CNT_ONE = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [PTR_WIDTH:0]    count_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  full;
   logic                  empty;
   logic                  wa;
   logic                  ra;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   assign wa    = bus.wr_en && !full;
   assign ra    = bus.rd_en && !empty;

   // Thresholds above DEPTH fall out naturally: count can never reach them,
   // and any ae_thresh >= DEPTH is always satisfied.
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

   // Storage is not reset; pointers and count alone define valid contents.
   always_ff @(posedge clk) begin
      if (wa) begin
         mem[wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wa) wr_ptr <= wr_ptr + PTR_ONE;
         if (ra) rd_ptr <= rd_ptr + PTR_ONE;
         if (wa && !ra)      count_q <= count_q + CNT_ONE;
         else if (ra && !wa) count_q <= count_q - CNT_ONE;
         // A new error in the same cycle as clr_err keeps the flag set.
         overflow_q  <= (bus.wr_en && full)  || (overflow_q  && !bus.clr_err);
         underflow_q <= (bus.rd_en && empty) || (underflow_q && !bus.clr_err);
      end
   end

   if (FWFT) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty
      // so the output is defined after reset.
      assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
      assign bus.rd_valid = !empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= ra;
            if (ra) rd_data_q <= mem[rd_ptr];
         end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
   end

endmodule

// File: tb/tb_fifo_prog_sync.sv
// tb_fifo_prog_sync: directed bench for fifo_prog_sync in both read modes.
// A standard-mode instance is tracked cycle by cycle against a queue-based
// scoreboard; a FWFT instance is checked at directed points.
module tb_fifo_prog_sync;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 256;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;

   always #5 clk = ~clk;

   fifo_prog_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) a0 ();
   fifo_prog_sync_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) a1 ();

   fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (a0.slave)
   );

   fifo_prog_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (a1.slave)
   );

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   // scoreboard state for dut0
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   int unsigned   m_count = 0;
   logic          m_ovf   = 1'b0;
   logic          m_udf   = 1'b0;
   logic          m_rv    = 1'b0;
   logic [DW-1:0] m_rd    = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle; updates the dut0 scoreboard and checks all its outputs.
   task automatic step();
      logic          wa, ra, was_full, was_empty, wr, rd, clr, r;
      logic [DW-1:0] wd;
      was_full  = (m_count == DEPTH);
      was_empty = (m_count == 0);
      wr  = a0.wr_en;
      rd  = a0.rd_en;
      clr = a0.clr_err;
      wd  = a0.wr_data;
      r   = rst0;
      wa  = wr && !was_full;
      ra  = rd && !was_empty;
      @(posedge clk);
      #1;
      if (r) begin
         q0.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rv  = 1'b0;
         m_rd  = '0;
      end else begin
         if (ra) m_rd = q0.pop_front();
         if (wa) q0.push_back(wd);
         m_rv  = ra;
         m_ovf = (wr && was_full)  || (m_ovf && !clr);
         m_udf = (rd && was_empty) || (m_udf && !clr);
      end
      m_count = q0.size();
      chk("count",        64'(a0.count),        64'(m_count));
      chk("full",         64'(a0.full),         64'(m_count == DEPTH));
      chk("empty",        64'(a0.empty),        64'(m_count == 0));
      chk("almost_full",  64'(a0.almost_full),  64'(m_count >= int'(a0.af_thresh)));
      chk("almost_empty", 64'(a0.almost_empty), 64'(m_count <= int'(a0.ae_thresh)));
      chk("rd_valid",     64'(a0.rd_valid),     64'(m_rv));
      chk("rd_data",      64'(a0.rd_data),      64'(m_rd));
      chk("overflow",     64'(a0.overflow),     64'(m_ovf));
      chk("underflow",    64'(a0.underflow),    64'(m_udf));
   endtask

   initial begin
      logic [DW-1:0] d;
      rst0 = 1'b1; rst1 = 1'b1;
      a0.wr_en = 1'b0; a0.rd_en = 1'b0; a0.wr_data = '0; a0.clr_err = 1'b0;
      a0.af_thresh = '0; a0.ae_thresh = 9'd10;
      a1.wr_en = 1'b0; a1.rd_en = 1'b0; a1.wr_data = '0; a1.clr_err = 1'b0;
      a1.af_thresh = 9'd2; a1.ae_thresh = 9'd0;

      // reset with af_thresh=0 shows almost_full asserted
      step();
      a0.af_thresh = 9'd200;
      step();
      rst0 = 1'b0; rst1 = 1'b0;
      step();
      chk("fwft_reset_empty", 64'(a1.empty),    64'd1);
      chk("fwft_reset_rv",    64'(a1.rd_valid), 64'd0);

      // fill to full with the A5A5 pattern, then overflow attempt
      for (int i = 1; i <= 256; i++) begin
         a0.wr_en = 1'b1; a0.wr_data = 32'hA5A5_0000 + 32'(i);
         step();
      end
      a0.wr_data = 32'hDEAD_BEEF;
      step();
      a0.wr_en = 1'b0;
      chk("full_after_256", 64'(a0.full), 64'd1);
      a0.clr_err = 1'b1; step(); a0.clr_err = 1'b0;

      // drain all 256 in order
      a0.rd_en = 1'b1;
      for (int i = 0; i < 256; i++) step();
      a0.rd_en = 1'b0;
      step();
      chk("empty_after_drain", 64'(a0.empty), 64'd1);

      // almost_full at 200, almost_empty at 10
      for (int i = 0; i < 200; i++) begin
         a0.wr_en = 1'b1; a0.wr_data = 32'h0B00_0000 + 32'(i);
         step();
      end
      a0.wr_en = 1'b0;
      a0.rd_en = 1'b1;
      for (int i = 0; i < 190; i++) step();
      a0.rd_en = 1'b0;
      chk("ae_at_10", 64'(a0.almost_empty), 64'd1);

      // back to full, then simultaneous read/write while full
      for (int i = 0; i < 246; i++) begin
         a0.wr_en = 1'b1; a0.wr_data = 32'h0C00_0000 + 32'(i);
         step();
      end
      a0.rd_en = 1'b1; a0.wr_data = 32'h0D00_0000;
      step();
      a0.rd_en = 1'b0; a0.wr_en = 1'b0;
      chk("full_rw_count", 64'(a0.count), 64'd255);
      a0.clr_err = 1'b1; step(); a0.clr_err = 1'b0;
      a0.wr_en = 1'b1; a0.wr_data = 32'h0D00_0001; step();
      a0.clr_err = 1'b1; a0.wr_data = 32'h0D00_0002; step();
      a0.wr_en = 1'b0;
      chk("ovf_set_wins", 64'(a0.overflow), 64'd1);
      step();
      a0.clr_err = 1'b0;

      // drain, then simultaneous read/write while empty
      a0.rd_en = 1'b1;
      for (int i = 0; i < 256; i++) step();
      a0.wr_en = 1'b1; a0.wr_data = 32'h0E00_0000;
      step();
      chk("empty_rw_udf", 64'(a0.underflow), 64'd1);
      // continuous streaming across pointer wrap at constant occupancy
      for (int i = 1; i <= 1000; i++) begin
         a0.wr_data = 32'h0E00_0000 + 32'(i);
         step();
      end
      a0.wr_en = 1'b0; a0.rd_en = 1'b0;

      // out-of-range thresholds
      a0.af_thresh = 9'd300; a0.ae_thresh = 9'd256; step();
      chk("af_never", 64'(a0.almost_full),  64'd0);
      chk("ae_always", 64'(a0.almost_empty), 64'd1);
      a0.af_thresh = 9'd1; a0.ae_thresh = 9'd0; step();

      // reset mid-burst
      a0.wr_en = 1'b1; a0.wr_data = 32'h0F00_0000; step();
      rst0 = 1'b1; a0.rd_en = 1'b1; step();
      rst0 = 1'b0; a0.wr_en = 1'b0; a0.rd_en = 1'b0;
      step();

      // FWFT: word written to empty appears after the write edge
      a1.wr_en = 1'b1; a1.wr_data = 32'h1234_5678; step();
      a1.wr_en = 1'b0;
      chk("fwft_rv",   64'(a1.rd_valid), 64'd1);
      chk("fwft_data", 64'(a1.rd_data),  64'h1234_5678);
      step();
      chk("fwft_hold", 64'(a1.rd_data),  64'h1234_5678);
      a1.rd_en = 1'b1; step();
      chk("fwft_pop_empty", 64'(a1.empty),    64'd1);
      chk("fwft_pop_rv",    64'(a1.rd_valid), 64'd0);
      step();
      a1.rd_en = 1'b0;
      chk("fwft_udf", 64'(a1.underflow), 64'd1);

      // FWFT burst via scoreboard
      for (int i = 0; i < 4; i++) begin
         a1.wr_en = 1'b1; a1.wr_data = 32'h5500_0000 + 32'(i * 7);
         q1.push_back(a1.wr_data);
         step();
      end
      a1.wr_en = 1'b0;
      chk("fwft_af", 64'(a1.almost_full), 64'd1);
      a1.rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = q1.pop_front();
         chk("fwft_head_rv", 64'(a1.rd_valid), 64'd1);
         chk("fwft_head",    64'(a1.rd_data),  64'(d));
         step();
      end
      a1.rd_en = 1'b0;
      chk("fwft_burst_empty", 64'(a1.empty), 64'd1);

      // FWFT reset mid-burst
      a1.wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a1.wr_data = 32'h6600_0000 + 32'(i);
         step();
      end
      rst1 = 1'b1; step();
      rst1 = 1'b0; a1.wr_en = 1'b0;
      chk("fwft_rst_count", 64'(a1.count),     64'd0);
      chk("fwft_rst_empty", 64'(a1.empty),     64'd1);
      chk("fwft_rst_rv",    64'(a1.rd_valid),  64'd0);
      chk("fwft_rst_udf",   64'(a1.underflow), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_prog_sync.md
Name: fifo_prog_sync

Overview:
- Parametrised synchronous FIFO; successor to the fixed 32x256 FIFO.
- Adds:
  - run-time programmable almost-full/almost-empty thresholds
  - occupancy count output
  - sticky overflow/underflow error flags
  - selectable first-word-fall-through (FWFT) read mode
- Sits between producers (function generator samples) and consumers (SPI serializer) in the same clock domain.

Parameters:
DATA_WIDTH, 32, word width in bits
DEPTH, 256, number of entries; must be a power of two, >= 4
PTR_WIDTH, $clog2(DEPTH), read/write pointer width (derived, do not override)
FWFT, 0, 0 = standard read (data one cycle after rd_en), 1 = first-word-fall-through

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request / pop
rd_data  out  DATA_WIDTH  read word
rd_valid  out  1  rd_data holds a valid popped (standard) or head (FWFT) word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
af_thresh  in  PTR_WIDTH+1  almost-full threshold, sampled every cycle
ae_thresh  in  PTR_WIDTH+1  almost-empty threshold, sampled every cycle
count  out  PTR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at clock edge):
  - pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - empty=1, full=0, almost_empty=1.
  - almost_full = (af_thresh==0).
  - Reset overrides all other inputs in that cycle; FIFO contents are discarded, and storage RAM need not be cleared.
- Write accepted: wr_en && !full. Word stored at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Read accepted: rd_en && !empty. rd_ptr increments modulo DEPTH.
- Full/empty boundaries:
  - Write while full is dropped and sets overflow; contents and count are unchanged.
  - Read while empty sets underflow. Pointers and count are unchanged, and rd_valid stays 0 in standard mode.
- Simultaneous accepted read and write: count unchanged.
  - When full, only the read is accepted; the write is rejected and flags overflow.
  - When empty, only the write is accepted; the read is rejected and flags underflow.
- count: registered. Next value is count + wa - ra, where wa/ra = write/read accepted.
- Status flags are combinational functions of the registered count and the live thresholds, so they reflect state after the last edge.
  - Threshold > DEPTH: almost_full is never asserted.
  - ae_thresh >= DEPTH: almost_empty is always asserted.
- Standard mode (FWFT=0):
  - On an accepted read, rd_data is loaded with mem[rd_ptr] at the edge and rd_valid=1 for the following cycle only.
  - rd_data holds its last value otherwise. Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] whenever !empty; rd_valid = !empty.
  - rd_en acknowledges and pops the head.
  - A word written into an empty FIFO appears on rd_data/rd_valid the cycle after the write edge.
- Sticky errors:
  - Set on the offending cycle and held until clr_err.
  - If a set condition and clr_err occur in the same cycle, set wins.
- Memory: inferred simple dual-port array, DEPTH x DATA_WIDTH; no read-during-write hazard because full/empty gating prevents same-address conflicts.
- Mid-operation reset: takes effect at the next edge irrespective of wr_en/rd_en; the cycle after shows the reset state.

Test Plan:
- Reset then idle -> count=0, empty=1, full=0, almost_empty=1, rd_valid=0, overflow=underflow=0.
- FWFT=0: write 0xA5A5_0001..0xA5A5_0100 (256 words) -> full=1, count=256. Next wr_en -> overflow=1, count stays 256. Read all 256 -> data in order, each rd_valid 1 cycle after rd_en, empty=1 at end.
- af_thresh=200, ae_thresh=10: write 200 words -> almost_full rises the cycle after the 200th write. Read 190 -> almost_empty rises when count=10.
- Full FIFO, simultaneous wr_en+rd_en -> read accepted, write rejected, count=255, overflow=1. Then clr_err=1 alone -> overflow=0. clr_err together with a new overflow -> overflow stays 1.
- Empty FIFO, simultaneous wr_en+rd_en -> count=1, underflow=1, rd_valid=0. Continuous write+read for 1000 cycles across pointer wrap -> count constant, data in order.
- FWFT=1: write 0x1234_5678 into empty -> next cycle rd_valid=1, rd_data=0x1234_5678 without rd_en. Assert rd_en -> empty=1, rd_valid=0. Assert rst mid-burst -> next cycle count=0, empty=1.
